clk_stall_ctrl: RTL and testbench

- Parametrised successor to the fixed oscillator divider and the single-source clock-stall gate used at the top level.
- Derives a programmable-ratio processor clock enable and a 50%-duty divided clock from the fast oscillator clock.
- Merges N memory/peripheral stall requests into a stall decision, with an optional watchdog timeout.
- Provides a saturating stall-cycle counter for performance measurement.
- Sits between the SB_HFOSC output and the cpu/data memory. It replaces gated clocks with an enable (proc_en) and a glitch-free registered clock (clk_div).

---
 rtl/clk_stall_ctrl.sv | 122 ++++++++++++
 tb/tb_clk_stall_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_stall_ctrl.sv
// clk_stall_ctrl: programmable clock-enable divider with merged stall gating,
// stall watchdog and saturating stall-cycle statistics counter.
// Ports: clk, rst_n (async, active-low); div_ld/div_val load a new ratio;
// stall_req per-source stall levels; clr_cnt clears stats.
// Outputs (all registered): tick, proc_en, clk_div, stalled, timeout, stall_cnt.
module clk_stall_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4,
  parameter int N_STALL     = 2,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               div_ld,
  input  logic [DIV_W-1:0]   div_val,
  input  logic [N_STALL-1:0] stall_req,
  input  logic               clr_cnt,
  output logic               tick,
  output logic               proc_en,
  output logic               clk_div,
  output logic               stalled,
  output logic               timeout,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int TO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pvld_q, pvld_d;
  logic             tick_q, tick_d;
  logic             pen_q, pen_d;
  logic             cdiv_q, cdiv_d;
  logic             stl_q, stl_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [TO_W-1:0]  cons_q, cons_d;

  logic [DIV_W-1:0] ld_val;
  logic             term;
  logic             req;
  logic             fire_to;
  logic             hold;

  assign ld_val  = (div_val == '0) ? ONE : div_val;
  assign term    = (cnt_q == div_q - ONE);
  assign req     = |stall_req;
  assign fire_to = (TIMEOUT != 0) && (cons_q == TO_W'(TIMEOUT));
  // Stall is honoured only on a terminal edge and when the watchdog is quiet.
  assign hold    = term && req && !fire_to;

  always_comb begin
    cnt_d  = term ? '0 : cnt_q + ONE;
    div_d  = div_q;
    pend_d = pend_q;
    pvld_d = pvld_q;
    if (term) begin
      // A load on the wrap edge itself beats any older pending value.
      if (div_ld) div_d = ld_val;
      else if (pvld_q) div_d = pend_q;
      pvld_d = 1'b0;
    end else if (div_ld) begin
      pend_d = ld_val;
      pvld_d = 1'b1;
    end
  end

  always_comb begin
    tick_d = term;
    pen_d  = term && (!req || fire_to);
    to_d   = term && req && fire_to;
    cdiv_d = term ? ~cdiv_q : cdiv_q;
    stl_d  = term ? hold : stl_q;
    cons_d = cons_q;
    if (TIMEOUT != 0 && term)
      cons_d = hold ? cons_q + TO_W'(1) : '0;
    scnt_d = scnt_q;
    if (clr_cnt) scnt_d = '0;
    else if (hold && scnt_q != '1)
      scnt_d = scnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= DEF_DIV;
      pend_q <= DEF_DIV;
      pvld_q <= 1'b0;
      tick_q <= 1'b0;
      pen_q  <= 1'b0;
      cdiv_q <= 1'b0;
      stl_q  <= 1'b0;
      to_q   <= 1'b0;
      scnt_q <= '0;
      cons_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pend_q <= pend_d;
      pvld_q <= pvld_d;
      tick_q <= tick_d;
      pen_q  <= pen_d;
      cdiv_q <= cdiv_d;
      stl_q  <= stl_d;
      to_q   <= to_d;
      scnt_q <= scnt_d;
      cons_q <= cons_d;
    end
  end

  assign tick      = tick_q;
  assign proc_en   = pen_q;
  assign clk_div   = cdiv_q;
  assign stalled   = stl_q;
  assign timeout   = to_q;
  assign stall_cnt = scnt_q;

endmodule

// File: tb/tb_clk_stall_ctrl.sv
// Scoreboard bench for clk_stall_ctrl: expected tick records are queued by
// the stimulus and popped by a monitor whenever the DUT raises tick.
module tb_clk_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_ld;
  logic [7:0]  div_val;
  logic [1:0]  stall_req;
  logic        clr_cnt;
  logic        tick, proc_en, clk_div, stalled, timeout;
  logic [15:0] stall_cnt;

  logic        rst2_n;
  logic        div_ld2;
  logic [7:0]  div_val2;
  logic [1:0]  stall2;
  logic        clr2;
  logic        tick2, pen2, cdiv2, stl2, to2;
  logic [3:0]  scnt2;

  clk_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n), .div_ld(div_ld), .div_val(div_val),
    .stall_req(stall_req), .clr_cnt(clr_cnt), .tick(tick),
    .proc_en(proc_en), .clk_div(clk_div), .stalled(stalled),
    .timeout(timeout), .stall_cnt(stall_cnt)
  );

  clk_stall_ctrl #(
    .DEFAULT_DIV(1), .TIMEOUT(0), .CNT_W(4)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .div_ld(div_ld2), .div_val(div_val2),
    .stall_req(stall2), .clr_cnt(clr2), .tick(tick2),
    .proc_en(pen2), .clk_div(cdiv2), .stalled(stl2),
    .timeout(to2), .stall_cnt(scnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          en;
    logic        pen;
    logic        to;
    logic        stl;
    logic        cdiv;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int ecnt;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) ecnt <= 0;
    else ecnt <= ecnt + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  task automatic push(int e, logic p, logic t, logic s, logic c, int n);
    exp_t r;
    r.en = e; r.pen = p; r.to = t; r.stl = s; r.cdiv = c;
    r.cnt = 16'(n);
    q.push_back(r);
  endtask

  task automatic wait_edge(int n);
    int g = 0;
    while (ecnt < n && g < 2000) begin
      @(negedge clk);
      g++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && tick === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tick: got tick at edge %0d want none", ecnt);
      end else begin
        exp_t r;
        r = q.pop_front();
        chk("tick_edge", ecnt, r.en);
        chk("proc_en", proc_en, r.pen);
        chk("timeout", timeout, r.to);
        chk("stalled", stalled, r.stl);
        chk("clk_div", clk_div, r.cdiv);
        chk("stall_cnt", stall_cnt, r.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; div_ld = 1'b0; div_val = '0;
    stall_req = '0; clr_cnt = 1'b0;
    rst2_n = 1'b0; div_ld2 = 1'b0; div_val2 = '0;
    stall2 = '0; clr2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tick", tick, 0);
    chk("rst_pen", proc_en, 0);
    chk("rst_cdiv", clk_div, 0);
    chk("rst_stl", stalled, 0);
    chk("rst_to", timeout, 0);
    chk("rst_cnt", stall_cnt, 0);

    // Narrow counter, ratio 1, no watchdog: saturation and clear priority.
    rst2_n = 1'b1;
    stall2 = 2'b11;
    repeat (20) @(negedge clk);
    chk("sat_cnt", scnt2, 15);
    chk("sat_pen", pen2, 0);
    chk("sat_tick", tick2, 1);
    chk("sat_stl", stl2, 1);
    chk("sat_to", to2, 0);
    clr2 = 1'b1;
    @(negedge clk);
    chk("clr_win", scnt2, 0);
    clr2 = 1'b0;
    @(negedge clk);
    chk("clr_next", scnt2, 1);
    stall2 = '0;

    // Default ratio, then reprogramming to 3, 0 (=1) and 4 on a wrap edge.
    push(4, 1, 0, 0, 1, 0);
    push(7, 1, 0, 0, 0, 0);
    push(10, 1, 0, 0, 1, 0);
    push(13, 1, 0, 0, 0, 0);
    push(16, 1, 0, 0, 1, 0);
    push(17, 1, 0, 0, 0, 0);
    push(18, 1, 0, 0, 1, 0);
    push(19, 1, 0, 0, 0, 0);
    push(23, 1, 0, 0, 1, 0);
    push(27, 1, 0, 0, 0, 0);
    push(31, 1, 0, 0, 1, 0);
    rst_n = 1'b1;
    wait_edge(1);  div_ld = 1'b1; div_val = 8'd3;
    wait_edge(2);  div_ld = 1'b0;
    wait_edge(13); div_ld = 1'b1; div_val = 8'd0;
    wait_edge(14); div_ld = 1'b0;
    wait_edge(18); div_ld = 1'b1; div_val = 8'd4;
    wait_edge(19); div_ld = 1'b0;

    // Three stalled ticks, plus a between-tick glitch that must be ignored.
    wait_edge(31);
    stall_req = 2'b10;
    push(35, 0, 0, 1, 0, 1);
    push(39, 0, 0, 1, 1, 2);
    push(43, 0, 0, 1, 0, 3);
    push(47, 1, 0, 0, 1, 3);
    wait_edge(43); stall_req = 2'b00;
    wait_edge(44); stall_req = 2'b01;
    wait_edge(45); stall_req = 2'b00;

    // Permanent stall: watchdog release on the 17th tick.
    wait_edge(47);
    stall_req = 2'b01;
    clr_cnt = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      if (k < 16)       push(51 + 4 * k, 0, 0, 1, k[0], k + 1);
      else if (k == 16) push(51 + 4 * k, 1, 1, 0, k[0], 16);
      else              push(51 + 4 * k, 0, 0, 1, k[0], k);
    end
    push(183, 1, 0, 0, 1, 32);
    wait_edge(48);  clr_cnt = 1'b0;
    wait_edge(179); stall_req = 2'b00;

    // Build up clk_div=1 and stall_cnt=5 mid-stall, then reset.
    wait_edge(183);
    stall_req = 2'b11;
    push(187, 0, 0, 1, 0, 33);
    push(191, 0, 0, 1, 1, 1);
    push(195, 0, 0, 1, 0, 2);
    push(199, 0, 0, 1, 1, 3);
    push(203, 0, 0, 1, 0, 4);
    push(207, 0, 0, 1, 1, 5);
    wait_edge(187); clr_cnt = 1'b1;
    wait_edge(188); clr_cnt = 1'b0;
    wait_edge(208); div_ld = 1'b1; div_val = 8'd7;
    wait_edge(209); div_ld = 1'b0;
    chk("pre_stl", stalled, 1);
    chk("pre_cdiv", clk_div, 1);
    chk("pre_cnt", stall_cnt, 5);
    chk("pre_qempty", q.size(), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_tick", tick, 0);
    chk("mid_pen", proc_en, 0);
    chk("mid_cdiv", clk_div, 0);
    chk("mid_stl", stalled, 0);
    chk("mid_to", timeout, 0);
    chk("mid_cnt", stall_cnt, 0);
    @(negedge clk);
    stall_req = 2'b00;
    push(4, 1, 0, 0, 1, 0);
    push(8, 1, 0, 0, 0, 0);
    push(12, 1, 0, 0, 1, 0);
    rst_n = 1'b1;
    wait_edge(14);
    chk("end_qempty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
